// File: rtl/riscv_pkg.sv
// Shared RV32I types for the multi-cycle core: datapath select encodings,
// controller states, trap causes and the decoded control bundle.
package riscv_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } alu_op_e;

    typedef enum logic [1:0] {
        MEM_BYTE = 2'd0,
        MEM_HALF = 2'd1,
        MEM_WORD = 2'd2
    } mem_size_e;

    typedef enum logic [1:0] {
        ALU_A_RS1  = 2'd0,
        ALU_A_PC   = 2'd1,
        ALU_A_ZERO = 2'd2
    } alu_src_a_e;

    typedef enum logic {
        ALU_B_RS2 = 1'b0,
        ALU_B_IMM = 1'b1
    } alu_src_b_e;

    typedef enum logic [2:0] {
        IMM_I = 3'd0,
        IMM_S = 3'd1,
        IMM_B = 3'd2,
        IMM_U = 3'd3,
        IMM_J = 3'd4
    } imm_src_e;

    typedef enum logic [1:0] {
        PC_SRC_PC4        = 2'd0,
        PC_SRC_BRANCH_JAL = 2'd1,
        PC_SRC_JALR       = 2'd2
    } pc_src_e;

    typedef enum logic [1:0] {
        RESULT_SRC_ALU    = 2'd0,
        RESULT_SRC_MEM    = 2'd1,
        RESULT_SRC_PC4    = 2'd2,
        RESULT_SRC_MULDIV = 2'd3
    } result_src_e;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_e;

    typedef enum logic [1:0] {
        TRAP_NONE    = 2'd0,
        TRAP_ILLEGAL = 2'd1,
        TRAP_IMEM    = 2'd2,
        TRAP_DMEM    = 2'd3
    } trap_cause_e;

    localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
    localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
    localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
    localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
    localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
    localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
    localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPCODE_OP     = 7'b0110011;

    localparam logic [6:0] FUNCT7_BASE   = 7'b0000000;
    localparam logic [6:0] FUNCT7_ALT    = 7'b0100000;
    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    typedef struct packed {
        alu_op_e     alu_control;
        alu_src_a_e  alu_src_a_sel;
        alu_src_b_e  alu_src_b_sel;
        imm_src_e    imm_src;
        result_src_e result_src;
        mem_size_e   mem_size;
        logic        mem_usign_load;
        logic        is_load;
        logic        is_store;
        logic        is_branch;
        logic        is_jal;
        logic        is_jalr;
        logic        is_muldiv;
        logic [2:0]  funct3;
    } ctrl_bundle_t;

    localparam ctrl_bundle_t CTRL_DEFAULT = '{
        alu_control:    ALU_ADD,
        alu_src_a_sel:  ALU_A_RS1,
        alu_src_b_sel:  ALU_B_RS2,
        imm_src:        IMM_I,
        result_src:     RESULT_SRC_ALU,
        mem_size:       MEM_WORD,
        mem_usign_load: 1'b0,
        is_load:        1'b0,
        is_store:       1'b0,
        is_branch:      1'b0,
        is_jal:         1'b0,
        is_jalr:        1'b0,
        is_muldiv:      1'b0,
        funct3:         3'd0
    };

    // alt selects SUB for funct3=000 and SRA for funct3=101
    function automatic alu_op_e alu_op_from_funct(input logic [2:0] f3, input logic alt);
        alu_op_e op;
        case (f3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            3'b111:  op = ALU_AND;
            default: op = ALU_ADD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/instr_decoder.sv
// Combinational RV32I(M) decoder: opcode/funct fields to a control bundle
// plus an illegal-instruction flag.
module instr_decoder
    import riscv_pkg::*;
#(
    parameter bit ENABLE_M = 1'b0
) (
    input  logic [6:0]   opcode,
    input  logic [2:0]   funct3,
    input  logic [6:0]   funct7,
    output ctrl_bundle_t ctrl,
    output logic         illegal
);

    // Decode one instruction; anything not recognised raises illegal
    always_comb begin
        ctrl        = CTRL_DEFAULT;
        ctrl.funct3 = funct3;
        illegal     = 1'b0;
        case (opcode)
            OPCODE_LUI: begin
                ctrl.alu_src_a_sel = ALU_A_ZERO;
                ctrl.alu_src_b_sel = ALU_B_IMM;
                ctrl.imm_src       = IMM_U;
            end
            OPCODE_AUIPC: begin
                ctrl.alu_src_a_sel = ALU_A_PC;
                ctrl.alu_src_b_sel = ALU_B_IMM;
                ctrl.imm_src       = IMM_U;
            end
            OPCODE_JAL: begin
                ctrl.alu_src_a_sel = ALU_A_PC;
                ctrl.alu_src_b_sel = ALU_B_IMM;
                ctrl.imm_src       = IMM_J;
                ctrl.result_src    = RESULT_SRC_PC4;
                ctrl.is_jal        = 1'b1;
            end
            OPCODE_JALR: begin
                ctrl.alu_src_b_sel = ALU_B_IMM;
                ctrl.imm_src       = IMM_I;
                ctrl.result_src    = RESULT_SRC_PC4;
                ctrl.is_jalr       = 1'b1;
                illegal            = (funct3 != 3'b000);
            end
            OPCODE_BRANCH: begin
                ctrl.alu_control = ALU_SUB;
                ctrl.imm_src     = IMM_B;
                ctrl.is_branch   = 1'b1;
                illegal          = (funct3 == 3'b010) || (funct3 == 3'b011);
            end
            OPCODE_LOAD: begin
                ctrl.alu_src_b_sel  = ALU_B_IMM;
                ctrl.result_src     = RESULT_SRC_MEM;
                ctrl.is_load        = 1'b1;
                ctrl.mem_usign_load = funct3[2];
                case (funct3[1:0])
                    2'b00:   ctrl.mem_size = MEM_BYTE;
                    2'b01:   ctrl.mem_size = MEM_HALF;
                    2'b10:   illegal = funct3[2];
                    default: illegal = 1'b1;
                endcase
            end
            OPCODE_STORE: begin
                ctrl.alu_src_b_sel = ALU_B_IMM;
                ctrl.imm_src       = IMM_S;
                ctrl.is_store      = 1'b1;
                case (funct3)
                    3'b000:  ctrl.mem_size = MEM_BYTE;
                    3'b001:  ctrl.mem_size = MEM_HALF;
                    3'b010:  ctrl.mem_size = MEM_WORD;
                    default: illegal = 1'b1;
                endcase
            end
            OPCODE_OP_IMM: begin
                ctrl.alu_src_b_sel = ALU_B_IMM;
                ctrl.alu_control   = alu_op_from_funct(funct3,
                                         (funct3 == 3'b101) && (funct7 == FUNCT7_ALT));
                // shift-immediates carry funct7 in imm[11:5]
                if (funct3 == 3'b001) begin
                    illegal = (funct7 != FUNCT7_BASE);
                end else if (funct3 == 3'b101) begin
                    illegal = (funct7 != FUNCT7_BASE) && (funct7 != FUNCT7_ALT);
                end else begin
                    illegal = 1'b0;
                end
            end
            OPCODE_OP: begin
                if (funct7 == FUNCT7_MULDIV) begin
                    if (ENABLE_M) begin
                        ctrl.is_muldiv  = 1'b1;
                        ctrl.result_src = RESULT_SRC_MULDIV;
                    end else begin
                        illegal = 1'b1;
                    end
                end else if (funct7 == FUNCT7_BASE) begin
                    ctrl.alu_control = alu_op_from_funct(funct3, 1'b0);
                end else if ((funct7 == FUNCT7_ALT) &&
                             ((funct3 == 3'b000) || (funct3 == 3'b101))) begin
                    ctrl.alu_control = alu_op_from_funct(funct3, 1'b1);
                end else begin
                    illegal = 1'b1;
                end
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/mc_control_unit.sv
// Multi-cycle RV32I(M) control FSM: sequences FETCH/DECODE/EXEC/MEM/WB,
// handshakes with imem/dmem/mul-div, times out stalled buses into S_TRAP.
module mc_control_unit
    import riscv_pkg::*;
#(
    parameter bit          ENABLE_M    = 1'b0,
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       opcode,
    input  logic [2:0]       funct3,
    input  logic [6:0]       funct7,
    input  logic             zero_flag,
    input  logic             negative_flag,
    input  logic             carry_flag,
    input  logic             overflow_flag,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    input  logic             muldiv_done,
    output logic             imem_req,
    output logic             dmem_req,
    output logic             mem_write,
    output mem_size_e        mem_size,
    output logic             mem_usign_load,
    output logic             ir_write,
    output logic             pc_write,
    output logic             reg_write_enable,
    output logic             muldiv_start,
    output alu_op_e          alu_control,
    output alu_src_a_e       alu_src_a_sel,
    output alu_src_b_e       alu_src_b_sel,
    output imm_src_e         imm_src,
    output pc_src_e          pc_src,
    output result_src_e      result_src,
    output logic             trap,
    output trap_cause_e      trap_cause,
    output state_e           state,
    output logic [CNT_W-1:0] instret
);

    localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);

    ctrl_bundle_t dec_ctrl_s;
    logic         dec_illegal_s;
    ctrl_bundle_t ctrl_r;
    logic [7:0]   wait_cnt_r;
    logic         pc_write_r;
    pc_src_e      pc_src_r;
    logic         branch_taken_s;
    logic         store_retire_s;
    pc_src_e      wb_pc_src_s;

    instr_decoder #(.ENABLE_M(ENABLE_M)) u_decoder (
        .opcode  (opcode),
        .funct3  (funct3),
        .funct7  (funct7),
        .ctrl    (dec_ctrl_s),
        .illegal (dec_illegal_s)
    );

    assign alu_control   = ctrl_r.alu_control;
    assign alu_src_a_sel = ctrl_r.alu_src_a_sel;
    assign alu_src_b_sel = ctrl_r.alu_src_b_sel;
    assign imm_src       = ctrl_r.imm_src;
    assign result_src    = ctrl_r.result_src;

    // carry_flag is the carry-out of rs1 + ~rs2 + 1, so carry=0 means rs1 < rs2 unsigned
    always_comb begin
        case (ctrl_r.funct3)
            3'b000:  branch_taken_s = zero_flag;
            3'b001:  branch_taken_s = !zero_flag;
            3'b100:  branch_taken_s = negative_flag ^ overflow_flag;
            3'b101:  branch_taken_s = !(negative_flag ^ overflow_flag);
            3'b110:  branch_taken_s = !carry_flag;
            3'b111:  branch_taken_s = carry_flag;
            default: branch_taken_s = 1'b0;
        endcase
    end

    // Flags are only valid during EXEC and a store retires on the dmem_ready
    // cycle itself, so those two cases bypass the registered pc controls.
    always_comb begin
        store_retire_s = rst_n && (state == S_MEM) && ctrl_r.is_store && dmem_req && dmem_ready;
        pc_write       = pc_write_r | store_retire_s;
        if ((state == S_EXEC) && ctrl_r.is_branch) begin
            pc_src = branch_taken_s ? PC_SRC_BRANCH_JAL : PC_SRC_PC4;
        end else begin
            pc_src = pc_src_r;
        end
        if (ctrl_r.is_jal) begin
            wb_pc_src_s = PC_SRC_BRANCH_JAL;
        end else if (ctrl_r.is_jalr) begin
            wb_pc_src_s = PC_SRC_JALR;
        end else begin
            wb_pc_src_s = PC_SRC_PC4;
        end
    end

    // Main sequencer: state, registered enables/pulses, wait counter, instret
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state            <= S_FETCH;
            imem_req         <= 1'b0;
            dmem_req         <= 1'b0;
            mem_write        <= 1'b0;
            mem_size         <= CTRL_DEFAULT.mem_size;
            mem_usign_load   <= 1'b0;
            ir_write         <= 1'b0;
            pc_write_r       <= 1'b0;
            reg_write_enable <= 1'b0;
            muldiv_start     <= 1'b0;
            pc_src_r         <= PC_SRC_PC4;
            ctrl_r           <= CTRL_DEFAULT;
            trap             <= 1'b0;
            trap_cause       <= TRAP_NONE;
            wait_cnt_r       <= 8'd0;
            instret          <= '0;
        end else begin
            ir_write         <= 1'b0;
            pc_write_r       <= 1'b0;
            reg_write_enable <= 1'b0;
            muldiv_start     <= 1'b0;
            pc_src_r         <= PC_SRC_PC4;
            wait_cnt_r       <= 8'd0;
            case (state)
                S_FETCH: begin
                    // the first FETCH after reset spends one cycle raising imem_req
                    if (!imem_req) begin
                        imem_req <= 1'b1;
                    end else if (imem_ready) begin
                        imem_req <= 1'b0;
                        ir_write <= 1'b1;
                        state    <= S_DECODE;
                    end else if (wait_cnt_r == TIMEOUT_LAST) begin
                        imem_req   <= 1'b0;
                        trap       <= 1'b1;
                        trap_cause <= TRAP_IMEM;
                        state      <= S_TRAP;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + 8'd1;
                    end
                end
                S_DECODE: begin
                    ctrl_r <= dec_ctrl_s;
                    if (dec_illegal_s) begin
                        trap       <= 1'b1;
                        trap_cause <= TRAP_ILLEGAL;
                        state      <= S_TRAP;
                    end else begin
                        pc_write_r   <= dec_ctrl_s.is_branch;
                        muldiv_start <= dec_ctrl_s.is_muldiv;
                        state        <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (ctrl_r.is_branch) begin
                        instret  <= instret + CNT_W'(1);
                        imem_req <= 1'b1;
                        state    <= S_FETCH;
                    end else if (ctrl_r.is_load || ctrl_r.is_store) begin
                        dmem_req       <= 1'b1;
                        mem_write      <= ctrl_r.is_store;
                        mem_size       <= ctrl_r.mem_size;
                        mem_usign_load <= ctrl_r.mem_usign_load;
                        state          <= S_MEM;
                    end else if (ctrl_r.is_muldiv && !muldiv_done) begin
                        state <= S_EXEC;
                    end else begin
                        reg_write_enable <= 1'b1;
                        pc_write_r       <= 1'b1;
                        pc_src_r         <= wb_pc_src_s;
                        state            <= S_WB;
                    end
                end
                S_MEM: begin
                    if (dmem_ready) begin
                        dmem_req       <= 1'b0;
                        mem_write      <= 1'b0;
                        mem_usign_load <= 1'b0;
                        if (ctrl_r.is_store) begin
                            instret  <= instret + CNT_W'(1);
                            imem_req <= 1'b1;
                            state    <= S_FETCH;
                        end else begin
                            reg_write_enable <= 1'b1;
                            pc_write_r       <= 1'b1;
                            state            <= S_WB;
                        end
                    end else if (wait_cnt_r == TIMEOUT_LAST) begin
                        dmem_req       <= 1'b0;
                        mem_write      <= 1'b0;
                        mem_usign_load <= 1'b0;
                        trap           <= 1'b1;
                        trap_cause     <= TRAP_DMEM;
                        state          <= S_TRAP;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + 8'd1;
                    end
                end
                S_WB: begin
                    instret  <= instret + CNT_W'(1);
                    imem_req <= 1'b1;
                    state    <= S_FETCH;
                end
                S_TRAP: begin
                    state <= S_TRAP;
                end
                default: begin
                    trap       <= 1'b1;
                    trap_cause <= TRAP_ILLEGAL;
                    state      <= S_TRAP;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mc_control_unit.sv
// Directed bench for mc_control_unit: one M-enabled DUT and one M-disabled
// DUT share stimulus; both use MEM_TIMEOUT = 4.
module tb_mc_control_unit;
    import riscv_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, zero_flag, negative_flag, carry_flag, overflow_flag;
    logic       imem_ready, dmem_ready, muldiv_done;
    logic [6:0] opcode, funct7;
    logic [2:0] funct3;

    logic m_imem_req, m_dmem_req, m_mem_write, m_mem_usign_load, m_ir_write, m_pc_write;
    logic m_reg_write_enable, m_muldiv_start, m_trap;
    mem_size_e m_mem_size;   alu_op_e m_alu_control;
    alu_src_a_e m_alu_src_a_sel; alu_src_b_e m_alu_src_b_sel; imm_src_e m_imm_src;
    pc_src_e m_pc_src; result_src_e m_result_src; trap_cause_e m_trap_cause;
    state_e m_state; logic [31:0] m_instret;

    logic i_imem_req, i_dmem_req, i_mem_write, i_mem_usign_load, i_ir_write, i_pc_write;
    logic i_reg_write_enable, i_muldiv_start, i_trap;
    mem_size_e i_mem_size;   alu_op_e i_alu_control;
    alu_src_a_e i_alu_src_a_sel; alu_src_b_e i_alu_src_b_sel; imm_src_e i_imm_src;
    pc_src_e i_pc_src; result_src_e i_result_src; trap_cause_e i_trap_cause;
    state_e i_state; logic [31:0] i_instret;

    int checks = 0;
    int errors = 0;

    mc_control_unit #(.ENABLE_M(1'b1), .MEM_TIMEOUT(4), .CNT_W(32)) dut_m (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .funct7(funct7),
        .zero_flag(zero_flag), .negative_flag(negative_flag), .carry_flag(carry_flag),
        .overflow_flag(overflow_flag), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .muldiv_done(muldiv_done), .imem_req(m_imem_req), .dmem_req(m_dmem_req),
        .mem_write(m_mem_write), .mem_size(m_mem_size), .mem_usign_load(m_mem_usign_load),
        .ir_write(m_ir_write), .pc_write(m_pc_write), .reg_write_enable(m_reg_write_enable),
        .muldiv_start(m_muldiv_start), .alu_control(m_alu_control),
        .alu_src_a_sel(m_alu_src_a_sel), .alu_src_b_sel(m_alu_src_b_sel),
        .imm_src(m_imm_src), .pc_src(m_pc_src), .result_src(m_result_src), .trap(m_trap),
        .trap_cause(m_trap_cause), .state(m_state), .instret(m_instret)
    );

    mc_control_unit #(.ENABLE_M(1'b0), .MEM_TIMEOUT(4), .CNT_W(32)) dut_i (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .funct7(funct7),
        .zero_flag(zero_flag), .negative_flag(negative_flag), .carry_flag(carry_flag),
        .overflow_flag(overflow_flag), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .muldiv_done(muldiv_done), .imem_req(i_imem_req), .dmem_req(i_dmem_req),
        .mem_write(i_mem_write), .mem_size(i_mem_size), .mem_usign_load(i_mem_usign_load),
        .ir_write(i_ir_write), .pc_write(i_pc_write), .reg_write_enable(i_reg_write_enable),
        .muldiv_start(i_muldiv_start), .alu_control(i_alu_control),
        .alu_src_a_sel(i_alu_src_a_sel), .alu_src_b_sel(i_alu_src_b_sel),
        .imm_src(i_imm_src), .pc_src(i_pc_src), .result_src(i_result_src), .trap(i_trap),
        .trap_cause(i_trap_cause), .state(i_state), .instret(i_instret)
    );

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
        opcode = op;
        funct3 = f3;
        funct7 = f7;
    endtask

    initial begin
        rst_n = 1'b0; zero_flag = 1'b0; negative_flag = 1'b0; carry_flag = 1'b0;
        overflow_flag = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0; muldiv_done = 1'b0;
        set_instr(7'd0, 3'd0, 7'd0);
        step(); step();

        chk("rst_state", 32'(m_state), 32'(S_FETCH));
        chk("rst_imem_req", 32'(m_imem_req), 32'd0);
        chk("rst_pulses", {28'd0, m_ir_write, m_pc_write, m_reg_write_enable, m_muldiv_start}, 32'd0);
        chk("rst_trap_cause", 32'(m_trap_cause), 32'd0);
        chk("rst_instret", m_instret, 32'd0);
        chk("rst_alu", 32'(m_alu_control), 32'(ALU_ADD));
        chk("rst_pc_src", 32'(m_pc_src), 32'(PC_SRC_PC4));
        chk("rst_result_src", 32'(m_result_src), 32'(RESULT_SRC_ALU));

        // ADD with zero-wait imem
        rst_n = 1'b1; imem_ready = 1'b1;
        set_instr(OPCODE_OP, 3'b000, FUNCT7_BASE);
        step();
        chk("add_c0_imem_req", 32'(m_imem_req), 32'd1);
        step();
        chk("add_c1_ir_write", 32'(m_ir_write), 32'd1);
        chk("add_c1_state", 32'(m_state), 32'(S_DECODE));
        step();
        chk("add_c2_state", 32'(m_state), 32'(S_EXEC));
        chk("add_c2_ir_write", 32'(m_ir_write), 32'd0);
        chk("add_c2_src_b", 32'(m_alu_src_b_sel), 32'(ALU_B_RS2));
        step();
        chk("add_c3_reg_we", 32'(m_reg_write_enable), 32'd1);
        chk("add_c3_pc_write", 32'(m_pc_write), 32'd1);
        chk("add_c3_instret", m_instret, 32'd0);
        step();
        chk("add_c4_instret", m_instret, 32'd1);
        chk("add_c4_reg_we", 32'(m_reg_write_enable), 32'd0);
        chk("add_c4_state", 32'(m_state), 32'(S_FETCH));

        // LW with dmem_ready arriving on the 4th MEM cycle (the timeout cycle)
        set_instr(OPCODE_LOAD, 3'b010, 7'd0);
        dmem_ready = 1'b0;
        step(); step();
        chk("lw_src_b", 32'(m_alu_src_b_sel), 32'(ALU_B_IMM));
        step();
        chk("lw_mem1_req", 32'(m_dmem_req), 32'd1);
        chk("lw_mem_size", 32'(m_mem_size), 32'(MEM_WORD));
        chk("lw_mem_write", 32'(m_mem_write), 32'd0);
        step();
        chk("lw_mem2_req", 32'(m_dmem_req), 32'd1);
        step();
        chk("lw_mem3_req", 32'(m_dmem_req), 32'd1);
        step();
        dmem_ready = 1'b1;
        chk("lw_mem4_req", 32'(m_dmem_req), 32'd1);
        step();
        dmem_ready = 1'b0;
        chk("lw_wb_state", 32'(m_state), 32'(S_WB));
        chk("lw_wb_dmem_req", 32'(m_dmem_req), 32'd0);
        chk("lw_wb_reg_we", 32'(m_reg_write_enable), 32'd1);
        chk("lw_wb_result", 32'(m_result_src), 32'(RESULT_SRC_MEM));
        chk("lw_no_trap", 32'(m_trap), 32'd0);
        step();
        chk("lw_instret", m_instret, 32'd2);

        // BEQ taken then not taken
        set_instr(OPCODE_BRANCH, 3'b000, 7'd0);
        zero_flag = 1'b1;
        step(); step();
        chk("beq_t_pc_write", 32'(m_pc_write), 32'd1);
        chk("beq_t_pc_src", 32'(m_pc_src), 32'(PC_SRC_BRANCH_JAL));
        chk("beq_t_reg_we", 32'(m_reg_write_enable), 32'd0);
        step();
        chk("beq_t_instret", m_instret, 32'd3);
        chk("beq_t_reg_we_after", 32'(m_reg_write_enable), 32'd0);
        zero_flag = 1'b0;
        step(); step();
        chk("beq_n_pc_write", 32'(m_pc_write), 32'd1);
        chk("beq_n_pc_src", 32'(m_pc_src), 32'(PC_SRC_PC4));
        chk("beq_n_reg_we", 32'(m_reg_write_enable), 32'd0);
        step();
        chk("beq_n_instret", m_instret, 32'd4);

        // MUL: done five cycles after the start cycle; illegal without M
        set_instr(OPCODE_OP, 3'b000, FUNCT7_MULDIV);
        step(); step();
        chk("mul_start", 32'(m_muldiv_start), 32'd1);
        chk("mul_state", 32'(m_state), 32'(S_EXEC));
        chk("nom_trap", 32'(i_trap), 32'd1);
        chk("nom_cause", 32'(i_trap_cause), 32'(TRAP_ILLEGAL));
        chk("nom_start", 32'(i_muldiv_start), 32'd0);
        for (int k = 0; k < 4; k++) begin
            step();
            chk("mul_wait_start", 32'(m_muldiv_start), 32'd0);
            chk("mul_wait_state", 32'(m_state), 32'(S_EXEC));
        end
        step();
        muldiv_done = 1'b1;
        step();
        muldiv_done = 1'b0;
        chk("mul_wb_state", 32'(m_state), 32'(S_WB));
        chk("mul_wb_reg_we", 32'(m_reg_write_enable), 32'd1);
        chk("mul_wb_result", 32'(m_result_src), 32'(RESULT_SRC_MULDIV));
        step();
        chk("mul_instret", m_instret, 32'd5);
        chk("nom_still_trap", 32'(i_state), 32'(S_TRAP));
        chk("nom_instret", i_instret, 32'd4);

        // imem timeout with MEM_TIMEOUT = 4
        imem_ready = 1'b0;
        step(); step(); step();
        chk("imem_to_c4_trap", 32'(m_trap), 32'd0);
        chk("imem_to_c4_req", 32'(m_imem_req), 32'd1);
        step();
        chk("imem_to_trap", 32'(m_trap), 32'd1);
        chk("imem_to_cause", 32'(m_trap_cause), 32'(TRAP_IMEM));
        chk("imem_to_req_drop", 32'(m_imem_req), 32'd0);
        imem_ready = 1'b1;
        step(); step(); step();
        chk("trap_absorb_state", 32'(m_state), 32'(S_TRAP));
        chk("trap_absorb_ir", 32'(m_ir_write), 32'd0);

        // reset in the middle of a waiting SW
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        set_instr(OPCODE_STORE, 3'b010, 7'd0);
        dmem_ready = 1'b0;
        step(); step(); step(); step();
        chk("sw_mem_req", 32'(m_dmem_req), 32'd1);
        chk("sw_mem_write", 32'(m_mem_write), 32'd1);
        step();
        rst_n = 1'b0;
        step();
        chk("sw_rst_req", 32'(m_dmem_req), 32'd0);
        chk("sw_rst_state", 32'(m_state), 32'(S_FETCH));
        chk("sw_rst_instret", m_instret, 32'd0);

        // SW with zero-wait dmem retires on the ready cycle
        rst_n = 1'b1;
        dmem_ready = 1'b1;
        step(); step(); step(); step();
        chk("sw_zw_pc_write", 32'(m_pc_write), 32'd1);
        chk("sw_zw_reg_we", 32'(m_reg_write_enable), 32'd0);
        chk("sw_zw_pc_src", 32'(m_pc_src), 32'(PC_SRC_PC4));
        step();
        chk("sw_zw_instret", m_instret, 32'd1);
        chk("sw_zw_state", 32'(m_state), 32'(S_FETCH));
        chk("sw_zw_nom_instret", i_instret, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
